muxn_stream: RTL and testbench

Parametrised N-channel, W-bit stream multiplexer with a registered output and valid/ready handshaking on every port. It extends the single-bit 2:1 select function to N channels of arbitrary width. It adds flow control, a one-deep output register, and a selectable arbitration mode: external select or round-robin. It sits between multiple producers and a single consumer in datapath designs.

---
 rtl/muxn_stream_if.sv | 26 ++
 rtl/muxn_stream.sv | 118 +++++++++++
 tb/tb_muxn_stream.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muxn_stream_if.sv
// Stream bus between N producers and one consumer of the muxn_stream multiplexer.
// The slave modport is the multiplexer's view; the master modport drives producers/consumer.
interface muxn_stream_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
);
  logic [SW-1:0]  sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  grant;

  modport slave (
    input  sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, grant
  );

  modport master (
    output sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, grant
  );
endinterface

// File: rtl/muxn_stream.sv
// N-channel W-bit stream multiplexer with a one-deep registered output,
// selecting a channel either by external sel (RR=0) or by round-robin (RR=1).
module muxn_stream #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int RR = 0,
  parameter int SW = $clog2(N)
) (
  input logic          clk,
  input logic          n_reset,
  muxn_stream_if.slave bus
);

  logic [W-1:0]  r_out_data;
  logic          r_out_valid;
  logic [SW-1:0] r_grant;
  logic [SW-1:0] r_ptr;

  logic          w_load;
  logic          w_xfer;
  logic          w_choice_valid;
  logic          w_sel_valid;
  logic          w_rr_found;
  logic [SW-1:0] w_c;
  logic [SW-1:0] w_rr_c;
  logic [SW-1:0] w_idx;
  logic [SW-1:0] w_next_ptr;
  logic [N-1:0]  w_in_ready;
  logic [W-1:0]  w_in_beat;

  assign w_load = !r_out_valid || bus.out_ready;

  // First valid channel searching upward from the pointer, wrapping modulo N
  always_comb begin
    w_rr_c     = '0;
    w_rr_found = 1'b0;
    w_idx      = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = SW'((int'(r_ptr) + k) % N);
      if (!w_rr_found && bus.in_valid[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_c     = w_idx;
      end else begin
        w_rr_found = w_rr_found;
      end
    end
  end

  // Selected channel; codes at or above N (non power-of-2 N) select nothing
  always_comb begin
    w_sel_valid = 1'b0;
    if (int'(bus.sel) < N) begin
      w_sel_valid = bus.in_valid[bus.sel];
    end else begin
      w_sel_valid = 1'b0;
    end
  end

  always_comb begin
    w_c            = '0;
    w_choice_valid = 1'b0;
    if (RR != 0) begin
      w_c            = w_rr_c;
      w_choice_valid = w_rr_found;
    end else begin
      w_c            = bus.sel;
      w_choice_valid = w_sel_valid;
    end
  end

  // One-hot accept, held low through the reset cycle
  always_comb begin
    w_in_ready = '0;
    if (n_reset && w_load && w_choice_valid) begin
      w_in_ready[w_c] = 1'b1;
    end else begin
      w_in_ready = '0;
    end
  end

  assign w_xfer = |(w_in_ready & bus.in_valid);

  always_comb begin
    w_in_beat = '0;
    for (int i = 0; i < N; i++) begin
      if (SW'(i) == w_c) begin
        w_in_beat = bus.in_data[i*W +: W];
      end else begin
        w_in_beat = w_in_beat;
      end
    end
  end

  assign w_next_ptr = (int'(w_c) == N - 1) ? '0 : w_c + SW'(1);

  // Output register: load on transfer, drop valid on a drain with no refill
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_grant     <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_out_data  <= w_in_beat;
      r_out_valid <= 1'b1;
      r_grant     <= w_c;
      r_ptr       <= w_next_ptr;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.grant     = r_grant;

endmodule

// File: tb/tb_muxn_stream.sv
// Scoreboard bench for muxn_stream: select mode (N=4), round-robin (N=4) and
// select mode with a non power-of-2 channel count (N=3).
module tb_muxn_stream;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  muxn_stream_if #(.N(4), .W(8)) bus_a ();
  muxn_stream_if #(.N(4), .W(8)) bus_b ();
  muxn_stream_if #(.N(3), .W(8)) bus_c ();

  muxn_stream #(.N(4), .W(8), .RR(0)) u_sel4 (.clk(clk), .n_reset(n_reset), .bus(bus_a.slave));
  muxn_stream #(.N(4), .W(8), .RR(1)) u_rr4  (.clk(clk), .n_reset(n_reset), .bus(bus_b.slave));
  muxn_stream #(.N(3), .W(8), .RR(0)) u_sel3 (.clk(clk), .n_reset(n_reset), .bus(bus_c.slave));

  typedef struct {
    logic [7:0] d;
    logic [3:0] g;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int checks   = 0;
  int failures = 0;

  logic [7:0] b_data [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  int         rr_g   [10] = '{1, 3, 1, 3, 0, 1, 2, 3, 0, 1};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input int which, input logic [7:0] d, input logic [3:0] g);
    exp_t e;
    e.d = d;
    e.g = g;
    if (which == 0) q_a.push_back(e);
    else if (which == 1) q_b.push_back(e);
    else q_c.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every beat consumed on the output is popped and compared
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (n_reset === 1'b1 && bus_a.out_valid === 1'b1 && bus_a.out_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_extra_beat actual=%0h required=none", bus_a.out_data);
      end else begin
        e = q_a.pop_front();
        chk("a_data", 64'(bus_a.out_data), 64'(e.d));
        chk("a_grant", 64'(bus_a.grant), 64'(e.g));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (n_reset === 1'b1 && bus_b.out_valid === 1'b1 && bus_b.out_ready === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_extra_beat actual=%0h required=none", bus_b.out_data);
      end else begin
        e = q_b.pop_front();
        chk("b_data", 64'(bus_b.out_data), 64'(e.d));
        chk("b_grant", 64'(bus_b.grant), 64'(e.g));
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (n_reset === 1'b1 && bus_c.out_valid === 1'b1 && bus_c.out_ready === 1'b1) begin
      if (q_c.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL c_extra_beat actual=%0h required=none", bus_c.out_data);
      end else begin
        e = q_c.pop_front();
        chk("c_data", 64'(bus_c.out_data), 64'(e.d));
        chk("c_grant", 64'(bus_c.grant), 64'(e.g));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    n_reset         = 1'b0;
    bus_a.sel       = 2'd0;
    bus_a.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    bus_a.in_valid  = 4'hF;
    bus_a.out_ready = 1'b1;
    bus_b.sel       = 2'd0;
    bus_b.in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus_b.in_valid  = 4'hF;
    bus_b.out_ready = 1'b1;
    bus_c.sel       = 2'd0;
    bus_c.in_data   = {8'h77, 8'h66, 8'h55};
    bus_c.in_valid  = 3'b111;
    bus_c.out_ready = 1'b1;

    // Reset held with every channel valid
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_a_out_valid", 64'(bus_a.out_valid), 64'd0);
      chk("rst_a_out_data", 64'(bus_a.out_data), 64'd0);
      chk("rst_a_grant", 64'(bus_a.grant), 64'd0);
      chk("rst_a_in_ready", 64'(bus_a.in_ready), 64'd0);
      chk("rst_b_out_valid", 64'(bus_b.out_valid), 64'd0);
      chk("rst_b_in_ready", 64'(bus_b.in_ready), 64'd0);
      chk("rst_c_out_valid", 64'(bus_c.out_valid), 64'd0);
      chk("rst_c_in_ready", 64'(bus_c.in_ready), 64'd0);
    end
    step();
    bus_a.in_valid = 4'h0;
    bus_b.in_valid = 4'h0;
    bus_c.in_valid = 3'b000;
    n_reset        = 1'b1;

    // Select mode: sel steps 0..3
    push(0, 8'h11, 4'd0);
    push(0, 8'h22, 4'd1);
    push(0, 8'h33, 4'd2);
    push(0, 8'h44, 4'd3);
    bus_a.in_valid = 4'hF;
    for (int s = 0; s < 4; s++) begin
      bus_a.sel = 2'(s);
      @(negedge clk);
      chk("sel_in_ready", 64'(bus_a.in_ready), 64'd1 << s);
      step();
    end

    // Backpressure with beat 8'h22 held
    bus_a.sel = 2'd1;
    push(0, 8'h22, 4'd1);
    @(negedge clk);
    chk("bp_load_in_ready", 64'(bus_a.in_ready), 64'h2);
    step();
    bus_a.out_ready = 1'b0;
    bus_a.sel       = 2'd2;
    repeat (4) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(bus_a.out_valid), 64'd1);
      chk("bp_out_data", 64'(bus_a.out_data), 64'h22);
      chk("bp_grant", 64'(bus_a.grant), 64'd1);
      chk("bp_in_ready", 64'(bus_a.in_ready), 64'd0);
      step();
    end
    bus_a.out_ready = 1'b1;
    push(0, 8'h33, 4'd2);
    @(negedge clk);
    chk("drain_load_in_ready", 64'(bus_a.in_ready), 64'h4);
    step();
    bus_a.in_valid = 4'h0;
    @(negedge clk);
    chk("nobubble_out_valid", 64'(bus_a.out_valid), 64'd1);
    chk("nobubble_out_data", 64'(bus_a.out_data), 64'h33);
    step();

    // Round-robin: channels 1,3 only, then all channels
    for (int i = 0; i < 10; i++) begin
      bus_b.in_valid = (i < 4) ? 4'b1010 : 4'hF;
      push(1, b_data[rr_g[i]], 4'(rr_g[i]));
      @(negedge clk);
      chk("rr_in_ready", 64'(bus_b.in_ready), 64'd1 << rr_g[i]);
      step();
    end
    bus_b.in_valid = 4'h0;
    step();

    // Mid-stream reset during backpressure discards the held beat and the pointer
    bus_b.in_valid  = 4'hF;
    bus_b.out_ready = 1'b0;
    @(negedge clk);
    chk("rr_bp_in_ready", 64'(bus_b.in_ready), 64'h4);
    step();
    @(negedge clk);
    chk("rr_bp_grant", 64'(bus_b.grant), 64'd2);
    chk("rr_bp_stall_in_ready", 64'(bus_b.in_ready), 64'd0);
    step();
    n_reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(bus_b.in_ready), 64'd0);
    step();
    n_reset = 1'b1;
    push(1, 8'hA0, 4'd0);
    @(negedge clk);
    chk("midrst_out_valid", 64'(bus_b.out_valid), 64'd0);
    chk("midrst_first_in_ready", 64'(bus_b.in_ready), 64'h1);
    step();
    bus_b.in_valid  = 4'h0;
    bus_b.out_ready = 1'b1;
    step();

    // Non power-of-2: sel=3 on N=3 selects nothing
    bus_c.sel      = 2'd2;
    bus_c.in_valid = 3'b111;
    push(2, 8'h77, 4'd2);
    @(negedge clk);
    chk("n3_in_ready", 64'(bus_c.in_ready), 64'h4);
    step();
    bus_c.sel = 2'd3;
    @(negedge clk);
    chk("n3_sel3_in_ready", 64'(bus_c.in_ready), 64'd0);
    step();
    @(negedge clk);
    chk("n3_drained_valid", 64'(bus_c.out_valid), 64'd0);
    chk("n3_drained_in_ready", 64'(bus_c.in_ready), 64'd0);
    chk("n3_hold_data", 64'(bus_c.out_data), 64'h77);
    chk("n3_hold_grant", 64'(bus_c.grant), 64'd2);
    step();
    @(negedge clk);
    chk("n3_idle_valid", 64'(bus_c.out_valid), 64'd0);
    bus_c.in_valid = 3'b000;

    repeat (2) step();
    chk("a_queue_empty", 64'(q_a.size()), 64'd0);
    chk("b_queue_empty", 64'(q_b.size()), 64'd0);
    chk("c_queue_empty", 64'(q_c.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
